// File: rtl/can_pkg.sv
// Shared types and constants for the CAN transmit sequencer.
package can_pkg;

    localparam int unsigned CAN_ID_W   = 11;
    localparam int unsigned CAN_DLC_W  = 4;
    localparam int unsigned CAN_DATA_W = 64;

    typedef struct packed {
        logic [CAN_ID_W-1:0]   id;
        logic [CAN_DLC_W-1:0]  dlc;
        logic [CAN_DATA_W-1:0] data;
    } can_frame_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DONE = 2'd1,
        WAIT_ECHO = 2'd2,
        REPORT    = 2'd3
    } seq_state_t;

    localparam logic [1:0] ERR_MISMATCH     = 2'd0;
    localparam logic [1:0] ERR_TX_TIMEOUT   = 2'd1;
    localparam logic [1:0] ERR_ECHO_TIMEOUT = 2'd2;

endpackage

// File: rtl/can_frame_fifo.sv
// Synchronous frame FIFO with peekable head; writes while full are dropped.
module can_frame_fifo
    import can_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  can_frame_t             wr_frame,
    input  logic                   pop_en,
    output can_frame_t             head_c,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    can_frame_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic             push_c;
    logic             pop_c;
    logic [CNT_W-1:0] count_d;

    assign push_c = wr_en && !full;
    assign pop_c  = pop_en && !empty;
    assign head_c = mem[rd_ptr_q];

    always_comb begin
        count_d = count;
        if (push_c && !pop_c) begin
            count_d = count + CNT_W'(1);
        end else if (!push_c && pop_c) begin
            count_d = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count    <= count_d;
            full     <= (count_d == CNT_W'(DEPTH));
            empty    <= (count_d == '0);
            overflow <= wr_en && full;
        end
    end

    // Storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push_c) mem[wr_ptr_q] <= wr_frame;
    end

endmodule

// File: rtl/can_tx_sequencer.sv
// Issues queued host frames to the CAN transmitter one at a time and checks
// the loopback echo of each, reporting ok/error per frame.
module can_tx_sequencer
    import can_pkg::*;
#(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned TX_TIMEOUT   = 20000,
    parameter int unsigned ECHO_TIMEOUT = 2000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [10:0]            wr_id,
    input  logic [3:0]             wr_dlc,
    input  logic [63:0]            wr_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   tx_start,
    output logic [10:0]            tx_id,
    output logic [3:0]             tx_dlc,
    output logic [63:0]            tx_data,
    input  logic                   tx_busy,
    input  logic                   tx_done,
    input  logic                   rx_valid,
    input  logic [10:0]            rx_id,
    input  logic [3:0]             rx_dlc,
    input  logic [63:0]            rx_data,
    output logic                   frame_ok,
    output logic                   frame_err,
    output logic [1:0]             err_code,
    output logic                   overflow,
    output logic                   stray_rx,
    output logic [7:0]             err_cnt
);

    localparam int unsigned MAX_TO  = (TX_TIMEOUT > ECHO_TIMEOUT) ? TX_TIMEOUT : ECHO_TIMEOUT;
    localparam int unsigned TIMER_W = $clog2(MAX_TO) + 1;
    localparam logic [TIMER_W-1:0] TX_LAST   = TIMER_W'(TX_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] ECHO_LAST = TIMER_W'(ECHO_TIMEOUT - 1);

    seq_state_t         state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d, timer_inc_c;
    logic               echo_seen_q, echo_seen_d;
    logic               echo_ok_q, echo_ok_d;
    can_frame_t         tx_frame_q, tx_frame_d;
    can_frame_t         head_c, wr_frame_c;
    logic               pop_c, match_c, rep_c, rep_ok_c;
    logic [1:0]         rep_code_c;
    logic [3:0]         cmp_len_c;
    logic               tx_start_d, frame_ok_d, frame_err_d, stray_rx_d;
    logic [1:0]         err_code_d;
    logic [7:0]         err_cnt_d;

    assign wr_frame_c = {wr_id, wr_dlc, wr_data};
    assign tx_id      = tx_frame_q.id;
    assign tx_dlc     = tx_frame_q.dlc;
    assign tx_data    = tx_frame_q.data;

    can_frame_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_frame (wr_frame_c),
        .pop_en   (pop_c),
        .head_c   (head_c),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow)
    );

    // Echo compare: id and dlc exact, payload only over the first min(dlc,8) bytes.
    always_comb begin
        cmp_len_c = (tx_frame_q.dlc > 4'd8) ? 4'd8 : tx_frame_q.dlc;
        match_c   = (rx_id == tx_frame_q.id) && (rx_dlc == tx_frame_q.dlc);
        for (int i = 0; i < 8; i++) begin
            if ((4'(i) < cmp_len_c) &&
                (rx_data[CAN_DATA_W-1-8*i -: 8] != tx_frame_q.data[CAN_DATA_W-1-8*i -: 8])) begin
                match_c = 1'b0;
            end
        end
    end

    assign timer_inc_c = (timer_q == '1) ? timer_q : timer_q + TIMER_W'(1);

    always_comb begin
        state_d     = state_q;
        timer_d     = '0;
        echo_seen_d = echo_seen_q;
        echo_ok_d   = echo_ok_q;
        tx_frame_d  = tx_frame_q;
        tx_start_d  = 1'b0;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        err_code_d  = ERR_MISMATCH;
        stray_rx_d  = 1'b0;
        err_cnt_d   = err_cnt;
        pop_c       = 1'b0;
        rep_c       = 1'b0;
        rep_ok_c    = 1'b0;
        rep_code_c  = ERR_MISMATCH;

        case (state_q)
            IDLE: begin
                stray_rx_d = rx_valid;
                if (!empty && !tx_busy) begin
                    tx_frame_d  = head_c;
                    tx_start_d  = 1'b1;
                    echo_seen_d = 1'b0;
                    echo_ok_d   = 1'b0;
                    state_d     = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                timer_d = timer_inc_c;
                // Loopback echo may arrive before tx_done; keep only the first one.
                if (rx_valid && !echo_seen_q) begin
                    echo_seen_d = 1'b1;
                    echo_ok_d   = match_c;
                end
                if (tx_done) begin
                    if (echo_seen_q || rx_valid) begin
                        rep_c    = 1'b1;
                        rep_ok_c = echo_seen_q ? echo_ok_q : match_c;
                    end else begin
                        timer_d = '0;
                        state_d = WAIT_ECHO;
                    end
                end else if (timer_q >= TX_LAST) begin
                    rep_c      = 1'b1;
                    rep_code_c = ERR_TX_TIMEOUT;
                end
            end
            WAIT_ECHO: begin
                timer_d = timer_inc_c;
                if (rx_valid) begin
                    rep_c    = 1'b1;
                    rep_ok_c = match_c;
                end else if (timer_q >= ECHO_LAST) begin
                    rep_c      = 1'b1;
                    rep_code_c = ERR_ECHO_TIMEOUT;
                end
            end
            REPORT: begin
                stray_rx_d = rx_valid;
                pop_c      = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (rep_c) begin
            state_d = REPORT;
            if (rep_ok_c) begin
                frame_ok_d = 1'b1;
            end else begin
                frame_err_d = 1'b1;
                err_code_d  = rep_code_c;
                if (err_cnt != 8'hFF) err_cnt_d = err_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            echo_seen_q <= 1'b0;
            echo_ok_q   <= 1'b0;
            tx_frame_q  <= '0;
            tx_start    <= 1'b0;
            frame_ok    <= 1'b0;
            frame_err   <= 1'b0;
            err_code    <= ERR_MISMATCH;
            stray_rx    <= 1'b0;
            err_cnt     <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            echo_seen_q <= echo_seen_d;
            echo_ok_q   <= echo_ok_d;
            tx_frame_q  <= tx_frame_d;
            tx_start    <= tx_start_d;
            frame_ok    <= frame_ok_d;
            frame_err   <= frame_err_d;
            err_code    <= err_code_d;
            stray_rx    <= stray_rx_d;
            err_cnt     <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_can_tx_sequencer.sv
// Directed self-checking bench for can_tx_sequencer.
module tb_can_tx_sequencer;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TX_TO   = 20000;
    localparam int unsigned ECHO_TO = 2000;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [10:0] wr_id;
    logic [3:0]  wr_dlc;
    logic [63:0] wr_data;
    logic        full, empty;
    logic [2:0]  count;
    logic        tx_start;
    logic [10:0] tx_id;
    logic [3:0]  tx_dlc;
    logic [63:0] tx_data;
    logic        tx_busy, tx_done;
    logic        rx_valid;
    logic [10:0] rx_id;
    logic [3:0]  rx_dlc;
    logic [63:0] rx_data;
    logic        frame_ok, frame_err;
    logic [1:0]  err_code;
    logic        overflow, stray_rx;
    logic [7:0]  err_cnt;

    int errors = 0;
    int checks = 0;
    int n_start = 0, n_ok = 0, n_err = 0, n_ovf = 0;

    always #5 clk = ~clk;

    can_tx_sequencer #(.DEPTH(DEPTH), .TX_TIMEOUT(TX_TO), .ECHO_TIMEOUT(ECHO_TO)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_id(wr_id), .wr_dlc(wr_dlc), .wr_data(wr_data),
        .full(full), .empty(empty), .count(count),
        .tx_start(tx_start), .tx_id(tx_id), .tx_dlc(tx_dlc), .tx_data(tx_data),
        .tx_busy(tx_busy), .tx_done(tx_done),
        .rx_valid(rx_valid), .rx_id(rx_id), .rx_dlc(rx_dlc), .rx_data(rx_data),
        .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code),
        .overflow(overflow), .stray_rx(stray_rx), .err_cnt(err_cnt)
    );

    always @(negedge clk) begin
        if (tx_start)  n_start++;
        if (frame_ok)  n_ok++;
        if (frame_err) n_err++;
        if (overflow)  n_ovf++;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [10:0] id, input logic [3:0] dlc, input logic [63:0] data);
        wr_en = 1'b1; wr_id = id; wr_dlc = dlc; wr_data = data;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pulse_done();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    task automatic send_rx(input logic [10:0] id, input logic [3:0] dlc, input logic [63:0] data);
        rx_valid = 1'b1; rx_id = id; rx_dlc = dlc; rx_data = data;
        tick();
        rx_valid = 1'b0;
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return tx_start;
            1:       return frame_ok;
            2:       return frame_err;
            default: return 1'b0;
        endcase
    endfunction

    // Bounded wait; n == limit on expiry, which the callers' checks catch.
    task automatic wait_for(input int sel, input int limit, output int n);
        n = 0;
        while (!sig(sel) && n < limit) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        tick(); tick();
        checks++; if ({tx_start, frame_ok, frame_err, overflow, stray_rx, full} !== 6'b0) begin errors++; $display("FAIL reset_pulses: got %b expected 000000", {tx_start, frame_ok, frame_err, overflow, stray_rx, full}); end
        checks++; if (empty !== 1'b1 || count !== 3'd0) begin errors++; $display("FAIL reset_fifo: got empty=%b count=%0d expected empty=1 count=0", empty, count); end
        checks++; if (err_cnt !== 8'd0 || err_code !== 2'd0 || {tx_id, tx_dlc, tx_data} !== 79'd0) begin errors++; $display("FAIL reset_regs: got err_cnt=%0d err_code=%0d tx_id=%h expected zeros", err_cnt, err_code, tx_id); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic_echo();
        int n, s0;
        s0 = n_start;
        push(11'h123, 4'd2, 64'hAABB_0000_0000_0000);
        wait_for(0, 10, n);
        checks++; if (n !== 1) begin errors++; $display("FAIL basic_start_latency: got %0d expected 1", n); end
        checks++; if ({tx_id, tx_dlc, tx_data} !== {11'h123, 4'd2, 64'hAABB_0000_0000_0000}) begin errors++; $display("FAIL basic_tx_frame: got %h/%h/%h expected 123/2/aabb000000000000", tx_id, tx_dlc, tx_data); end
        repeat (3) tick();
        pulse_done();
        repeat (4) tick();
        send_rx(11'h123, 4'd2, 64'hAABB_0000_0000_0000);
        checks++; if (frame_ok !== 1'b1 || frame_err !== 1'b0) begin errors++; $display("FAIL basic_ok: got ok=%b err=%b expected ok=1 err=0", frame_ok, frame_err); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL basic_err_cnt: got %0d expected 0", err_cnt); end
        tick();
        checks++; if (empty !== 1'b1 || count !== 3'd0) begin errors++; $display("FAIL basic_pop: got empty=%b count=%0d expected 1/0", empty, count); end
        repeat (5) tick();
        checks++; if (n_start - s0 !== 1) begin errors++; $display("FAIL basic_single_start: got %0d expected 1", n_start - s0); end
    endtask

    task automatic test_compare();
        int n;
        push(11'h055, 4'd2, 64'hAABB_0000_0000_0000);
        wait_for(0, 10, n);
        push(11'h066, 4'd2, 64'hAABB_0000_0000_0000);
        push(11'h077, 4'd15, 64'h0123_4567_89AB_CDEF);
        push(11'h088, 4'd8, 64'h1122_3344_5566_7788);
        pulse_done();
        send_rx(11'h055, 4'd2, 64'hAABB_FF00_0000_0000);
        checks++; if (frame_ok !== 1'b1) begin errors++; $display("FAIL cmp_byte2_dontcare: got ok=%b expected 1", frame_ok); end
        wait_for(0, 10, n);
        checks++; if (n !== 2) begin errors++; $display("FAIL cmp_back_to_back: got %0d cycles expected 2", n); end
        checks++; if (tx_id !== 11'h066) begin errors++; $display("FAIL cmp_order: got %h expected 066", tx_id); end
        // Early echo with byte1 wrong, then a correct echo that must be ignored.
        send_rx(11'h066, 4'd2, 64'hAACC_0000_0000_0000);
        send_rx(11'h066, 4'd2, 64'hAABB_0000_0000_0000);
        pulse_done();
        checks++; if (frame_err !== 1'b1 || err_code !== 2'd0 || frame_ok !== 1'b0) begin errors++; $display("FAIL cmp_byte1_err: got err=%b code=%0d ok=%b expected 1/0/0", frame_err, err_code, frame_ok); end
        checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL cmp_err_cnt1: got %0d expected 1", err_cnt); end
        wait_for(0, 10, n);
        // tx_done and echo together, dlc above 8.
        rx_valid = 1'b1; rx_id = 11'h077; rx_dlc = 4'd15; rx_data = 64'h0123_4567_89AB_CDEF; tx_done = 1'b1;
        tick();
        rx_valid = 1'b0; tx_done = 1'b0;
        checks++; if (frame_ok !== 1'b1) begin errors++; $display("FAIL cmp_simul_done_rx: got ok=%b expected 1", frame_ok); end
        wait_for(0, 10, n);
        pulse_done();
        send_rx(11'h088, 4'd8, 64'h1122_3344_5566_7789);
        checks++; if (frame_err !== 1'b1 || err_cnt !== 8'd2) begin errors++; $display("FAIL cmp_last_byte: got err=%b cnt=%0d expected 1/2", frame_err, err_cnt); end
        tick();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL cmp_empty: got %b expected 1", empty); end
    endtask

    task automatic test_tx_timeout();
        int n;
        push(11'h3AA, 4'd1, 64'h5500_0000_0000_0000);
        wait_for(0, 10, n);
        wait_for(2, TX_TO + 10, n);
        checks++; if (n !== TX_TO) begin errors++; $display("FAIL txto_cycles: got %0d expected %0d", n, TX_TO); end
        checks++; if (frame_err !== 1'b1 || err_code !== 2'd1 || err_cnt !== 8'd3) begin errors++; $display("FAIL txto_code: got err=%b code=%0d cnt=%0d expected 1/1/3", frame_err, err_code, err_cnt); end
        tick();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL txto_empty: got %b expected 1", empty); end
    endtask

    task automatic test_echo_timeout();
        int n;
        push(11'h2BB, 4'd0, 64'h0);
        wait_for(0, 10, n);
        repeat (2) tick();
        pulse_done();
        wait_for(2, ECHO_TO + 10, n);
        checks++; if (n !== ECHO_TO) begin errors++; $display("FAIL echoto_cycles: got %0d expected %0d", n, ECHO_TO); end
        checks++; if (frame_err !== 1'b1 || err_code !== 2'd2 || err_cnt !== 8'd4) begin errors++; $display("FAIL echoto_code: got err=%b code=%0d cnt=%0d expected 1/2/4", frame_err, err_code, err_cnt); end
        tick();
        send_rx(11'h2BB, 4'd0, 64'h0);
        checks++; if (stray_rx !== 1'b1 || tx_start !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL stray_rx: got stray=%b start=%b empty=%b expected 1/0/1", stray_rx, tx_start, empty); end
        tick();
        checks++; if (stray_rx !== 1'b0 || frame_ok !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("FAIL stray_pulse: got stray=%b ok=%b err=%b expected 0/0/0", stray_rx, frame_ok, frame_err); end
    endtask

    task automatic test_overflow();
        int n, o0;
        logic [63:0] d;
        o0 = n_ovf;
        tx_busy = 1'b1;
        for (int i = 0; i < 5; i++) push(11'h100 + 11'(i), 4'd1, {8'(i + 1), 56'h0});
        tick();
        checks++; if (full !== 1'b1 || count !== 3'd4) begin errors++; $display("FAIL ovf_full: got full=%b count=%0d expected 1/4", full, count); end
        checks++; if (n_ovf - o0 !== 1) begin errors++; $display("FAIL ovf_pulses: got %0d expected 1", n_ovf - o0); end
        tx_busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_for(0, 10, n);
            checks++; if (tx_id !== 11'h100 + 11'(i)) begin errors++; $display("FAIL ovf_order%0d: got %h expected %h", i, tx_id, 11'h100 + 11'(i)); end
            pulse_done();
            d = {8'(i + 1), 56'h0};
            send_rx(11'h100 + 11'(i), 4'd1, d);
            checks++; if (frame_ok !== 1'b1) begin errors++; $display("FAIL ovf_ok%0d: got %b expected 1", i, frame_ok); end
            if (i == 0) begin
                // Write during the popping cycle while still full: must be dropped.
                push(11'h7FF, 4'd1, 64'hFF00_0000_0000_0000);
                checks++; if (overflow !== 1'b1 || count !== 3'd3) begin errors++; $display("FAIL ovf_pop_same_cycle: got ovf=%b count=%0d expected 1/3", overflow, count); end
            end
        end
        tick();
        checks++; if (empty !== 1'b1 || n_ovf - o0 !== 2 || err_cnt !== 8'd4) begin errors++; $display("FAIL ovf_drain: got empty=%b ovf=%0d cnt=%0d expected 1/2/4", empty, n_ovf - o0, err_cnt); end
    endtask

    task automatic test_reset_mid();
        int n, ok0, err0, s0;
        push(11'h011, 4'd1, 64'h1100_0000_0000_0000);
        wait_for(0, 10, n);
        push(11'h022, 4'd1, 64'h2200_0000_0000_0000);
        push(11'h033, 4'd1, 64'h3300_0000_0000_0000);
        pulse_done();
        repeat (2) tick();
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL rstmid_pre_count: got %0d expected 3", count); end
        rst = 1'b1;
        #1;
        checks++; if ({tx_start, frame_ok, frame_err, overflow, stray_rx, full, err_code} !== 8'd0 || err_cnt !== 8'd0 || {tx_id, tx_dlc, tx_data} !== 79'd0) begin errors++; $display("FAIL rstmid_outputs: got flags=%b err_cnt=%0d tx_id=%h expected zeros", {tx_start, frame_ok, frame_err, overflow, stray_rx, full, err_code}, err_cnt, tx_id); end
        checks++; if (empty !== 1'b1 || count !== 3'd0) begin errors++; $display("FAIL rstmid_fifo: got empty=%b count=%0d expected 1/0", empty, count); end
        ok0 = n_ok; err0 = n_err; s0 = n_start;
        repeat (2) tick();
        rst = 1'b0;
        repeat (20) tick();
        checks++; if (n_ok != ok0 || n_err != err0 || n_start != s0) begin errors++; $display("FAIL rstmid_no_report: got ok+%0d err+%0d start+%0d expected 0/0/0", n_ok - ok0, n_err - err0, n_start - s0); end
    endtask

    initial begin
        rst = 1'b1;
        wr_en = 1'b0; wr_id = '0; wr_dlc = '0; wr_data = '0;
        tx_busy = 1'b0; tx_done = 1'b0;
        rx_valid = 1'b0; rx_id = '0; rx_dlc = '0; rx_data = '0;
        test_reset();
        test_basic_echo();
        test_compare();
        test_tx_timeout();
        test_echo_timeout();
        test_overflow();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
